multi_timer: RTL and testbench
==============================

# multi_timer

Parametrised multi-channel down-counting timer peripheral on the CPU's memory-mapped bus. It provides CHANNELS independent timers, each with one-shot or auto-reload mode, an optional clock prescaler, a sticky pending flag and per-channel interrupt masking. It sits behind the bridge alongside other bus devices and drives one combined IRQ line into the CP0 interrupt inputs, plus a per-channel vector.

## Interface
- CHANNELS, 2: number of timer channels, 1..8.
- WIDTH, 32: COUNT/PRESET width, 8..32. Reads are zero-extended to 32 bits.
- CH_W, max(1,$clog2(CHANNELS)): channel-select width (derived).
- CLK  in  1  system clock; all state changes on posedge.
- RST  in  1  reset: synchronous, active-high.
- ADDR  in  CH_W+2  word address {channel, reg}; reg 0=CTRL, 1=PRESET, 2=COUNT (read-only), 3=STATUS.
- WE  in  1  write strobe for ADDR.
- WD  in  32  write data.
- RD  out  32  combinational read data for ADDR. Out-of-range channel reads 0.
- IRQ  out  1  OR of IRQ_VEC; registered.
- IRQ_VEC  out  CHANNELS  per channel: pending & IM.

## Operation
- CTRL fields: [0] EN; [2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as one-shot, stored as written); [3] IM (interrupt allow); [15:8] PRESCALE. All other bits read 0.
- STATUS: [0] pending (sticky). Writing 1 to bit 0 clears it; writing 0 has no effect.
- Writes to COUNT and to out-of-range channels are ignored.
- Each channel runs its own FSM with states IDLE, LOAD, CNT, INT:
  - IDLE: if EN, go to LOAD.
  - LOAD: COUNT<=PRESET, clear prescaler, go to CNT.
  - CNT: if !EN, go to IDLE. On a tick: if COUNT<=1, then COUNT<=0, pending<=1, go to INT; otherwise COUNT<=COUNT-1.
  - INT, one-shot: EN<=0, go to IDLE.
  - INT, auto-reload: COUNT<=PRESET, clear prescaler, go to CNT.
- Tick: the prescaler counts 0..PRESCALE; a tick fires when it equals PRESCALE, then it wraps to 0. PRESCALE=0 gives a tick every cycle.
- PRESET=0 behaves like PRESET=1.
- A CTRL write forces that channel's FSM to IDLE. It restarts via LOAD if the written EN=1. The CTRL write also clears pending.
- A PRESET write does not disturb counting. The new value is used at the next LOAD or reload.
- Bus-write priority: any write to a channel's register stalls that channel's FSM, COUNT and prescaler for that cycle. Other channels are unaffected.

## Timing
- Reset values: all CTRL/PRESET/COUNT/pending are 0, FSMs are IDLE, RD follows the zeroed registers, IRQ=0 and IRQ_VEC=0. These take effect at the first posedge with RST high. RST mid-count aborts immediately, with no IRQ.
- Edge numbering: a CTRL write with EN=1 is sampled at edge 0. LOAD is at edge 1; COUNT=PRESET=P after edge 2.
- With PRESCALE=S, COUNT decrements every S+1 cycles, and pending rises after edge 2+P·(S+1).
- IRQ_VEC is combinational from pending and IM. IRQ lags IRQ_VEC by one cycle.
- Auto-reload period is P·(S+1)+1 cycles, from pending-set to the next pending-set. The pending flag is not cleared by reload.
- A STATUS clear coinciding with a pending-set in the same cycle: the clear wins. The FSM stalls, so the set lands one cycle later and is not lost.
- Clearing IM masks IRQ_VEC the next cycle but keeps pending.

## Configuration
- TIMER_PRESCALER_EN defined: CTRL[15:8] is implemented as described above.
- TIMER_PRESCALER_EN undefined: the PRESCALE bits are not stored, read 0, and a tick fires every cycle. No prescaler flops are generated.

## Structure
- Package timer_pkg holds:
  - register-index localparams (REG_CTRL..REG_STATUS);
  - CTRL bit positions;
  - MODE encodings;
  - the FSM state enum (IDLE/LOAD/CNT/INT).
- Sub-module timer_channel holds one channel: its registers, FSM and prescaler. multi_timer instantiates CHANNELS copies in a generate loop and implements address decode, the RD mux and the IRQ OR/register.

## Test plan
- One-shot: ch0 PRESET=3, CTRL=0x9 → after edge 5, COUNT=0, pending=1, IRQ_VEC[0]=1; IRQ=1 one cycle later; CTRL reads 0x8.
- Auto-reload: ch1 PRESET=4, CTRL=0xB → pending at edge 6; COUNT reloads to 4; pending events recur every 5 cycles. STATUS write 1 clears pending; IRQ drops.
- Prescaler, with TIMER_PRESCALER_EN: PRESET=2, PRESCALE=3 → decrements every 4 cycles; pending after edge 10. Without the macro, pending after edge 4 and CTRL[15:8] reads 0.
- Simultaneous: STATUS clear in the exact cycle pending would set → pending is set one cycle later. A write to ch0 does not delay ch1's expiry.
- Disable/restart: while counting, CTRL EN=0 → IDLE, COUNT held, no IRQ. CTRL EN=1 → reload from PRESET with full latency.
- Reset mid-count: RST during CNT with IRQ high → next edge all registers 0, IRQ=0, IRQ_VEC=0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared register map, CTRL field positions, mode encodings and channel FSM states for multi_timer.
package timer_pkg;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_PRESET = 2'd1;
   localparam logic [1:0] REG_COUNT  = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   localparam int unsigned CTRL_EN      = 0;
   localparam int unsigned CTRL_MODE_LO = 1;
   localparam int unsigned CTRL_MODE_HI = 2;
   localparam int unsigned CTRL_IM      = 3;
   localparam int unsigned CTRL_PS_LO   = 8;
   localparam int unsigned CTRL_PS_HI   = 15;
   localparam int unsigned PS_W         = 8;

   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_RELOAD  = 2'b01;

   typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_e;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: CTRL/PRESET/COUNT/pending registers, FSM and optional prescaler.
// Prescaler storage and counter exist only when TIMER_PRESCALER_EN is defined.
module timer_channel
   import timer_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_we,
   input  logic [1:0]  i_wreg,
   input  logic [31:0] i_wd,
   input  logic [1:0]  i_rreg,
   output logic [31:0] o_rd_c,
   output logic        o_irq_c
);

   state_e             r_state;
   state_e             w_state_nxt;
   logic               r_en;
   logic [1:0]         r_mode;
   logic               r_im;
   logic [WIDTH-1:0]   r_preset;
   logic [WIDTH-1:0]   r_count;
   logic               r_pending;
   logic [WIDTH-1:0]   w_count_nxt;
   logic               w_pending_nxt;
   logic               w_en_nxt;
   logic               w_tick;
   logic [31:0]        w_ctrl;

`ifdef TIMER_PRESCALER_EN
   logic [PS_W-1:0]    r_prescale;
   logic [PS_W-1:0]    r_presc_cnt;

   assign w_tick = (r_presc_cnt == r_prescale);

   // Prescaler restarts on every (re)load and only advances while counting.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_presc_cnt <= '0;
      end else if (!i_we) begin
         if (r_state == LOAD || r_state == INT) begin
            r_presc_cnt <= '0;
         end else if (r_state == CNT && r_en) begin
            r_presc_cnt <= w_tick ? '0 : r_presc_cnt + PS_W'(1);
         end
      end
   end
`else
   assign w_tick = 1'b1;
`endif

   always_comb begin
      w_state_nxt   = r_state;
      w_count_nxt   = r_count;
      w_pending_nxt = r_pending;
      w_en_nxt      = r_en;
      case (r_state)
         IDLE: begin
            if (r_en) w_state_nxt = LOAD;
         end
         LOAD: begin
            w_count_nxt = r_preset;
            w_state_nxt = CNT;
         end
         CNT: begin
            if (!r_en) begin
               w_state_nxt = IDLE;
            end else if (w_tick) begin
               // PRESET of 0 expires on the first tick, same as 1
               if (r_count <= WIDTH'(1)) begin
                  w_count_nxt   = '0;
                  w_pending_nxt = 1'b1;
                  w_state_nxt   = INT;
               end else begin
                  w_count_nxt = r_count - WIDTH'(1);
               end
            end
         end
         INT: begin
            if (r_mode == MODE_RELOAD) begin
               w_count_nxt = r_preset;
               w_state_nxt = CNT;
            end else begin
               w_en_nxt    = 1'b0;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // A bus write to this channel takes priority and freezes the FSM for the cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= IDLE;
         r_en      <= 1'b0;
         r_mode    <= MODE_ONESHOT;
         r_im      <= 1'b0;
         r_preset  <= '0;
         r_count   <= '0;
         r_pending <= 1'b0;
`ifdef TIMER_PRESCALER_EN
         r_prescale <= '0;
`endif
      end else if (i_we) begin
         case (i_wreg)
            REG_CTRL: begin
               r_en      <= i_wd[CTRL_EN];
               r_mode    <= i_wd[CTRL_MODE_HI:CTRL_MODE_LO];
               r_im      <= i_wd[CTRL_IM];
               r_state   <= IDLE;
               r_pending <= 1'b0;
`ifdef TIMER_PRESCALER_EN
               r_prescale <= i_wd[CTRL_PS_HI:CTRL_PS_LO];
`endif
            end
            REG_PRESET: r_preset <= i_wd[WIDTH-1:0];
            REG_STATUS: if (i_wd[0]) r_pending <= 1'b0;
            default: ;
         endcase
      end else begin
         r_state   <= w_state_nxt;
         r_count   <= w_count_nxt;
         r_pending <= w_pending_nxt;
         r_en      <= w_en_nxt;
      end
   end

   always_comb begin
      w_ctrl = '0;
      w_ctrl[CTRL_EN] = r_en;
      w_ctrl[CTRL_MODE_HI:CTRL_MODE_LO] = r_mode;
      w_ctrl[CTRL_IM] = r_im;
`ifdef TIMER_PRESCALER_EN
      w_ctrl[CTRL_PS_HI:CTRL_PS_LO] = r_prescale;
`endif
      o_rd_c = '0;
      case (i_rreg)
         REG_CTRL:   o_rd_c = w_ctrl;
         REG_PRESET: o_rd_c = 32'(r_preset);
         REG_COUNT:  o_rd_c = 32'(r_count);
         default:    o_rd_c = {31'b0, r_pending};
      endcase
   end

   assign o_irq_c = r_pending & r_im;

endmodule

// File: rtl/multi_timer.sv
// Multi-channel down-counting timer: address decode, read mux and combined registered IRQ.
// Optional feature macro: TIMER_PRESCALER_EN (per-channel clock prescaler in CTRL[15:8]).
module multi_timer
   import timer_pkg::*;
#(
   parameter  int unsigned CHANNELS = 2,
   parameter  int unsigned WIDTH    = 32,
   localparam int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [CH_W+1:0]     i_addr,
   input  logic                i_we,
   input  logic [31:0]         i_wd,
   output logic [31:0]         o_rd,
   output logic                o_irq,
   output logic [CHANNELS-1:0] o_irq_vec
);

   logic [CH_W-1:0] w_ch;
   logic [1:0]      w_reg;
   logic [31:0]     w_rd_arr [CHANNELS];
   logic            r_irq;

   assign w_ch  = i_addr[CH_W+1:2];
   assign w_reg = i_addr[1:0];

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      timer_channel #(.WIDTH(WIDTH)) u_ch (
         .i_clk  (i_clk),
         .i_rst  (i_rst),
         .i_we   (i_we && (w_ch == CH_W'(g))),
         .i_wreg (w_reg),
         .i_wd   (i_wd),
         .i_rreg (w_reg),
         .o_rd_c (w_rd_arr[g]),
         .o_irq_c(o_irq_vec[g])
      );
   end

   // Channels beyond CHANNELS (non power-of-two counts) read as zero.
   always_comb begin
      o_rd = '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
         if (w_ch == CH_W'(i)) o_rd = w_rd_arr[i];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) r_irq <= 1'b0;
      else       r_irq <= |o_irq_vec;
   end

   assign o_irq = r_irq;

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer (CHANNELS=2, WIDTH=32), expectations hand-derived from edge timing.
`timescale 1ns/100ps
module tb_multi_timer;

   logic        clk;
   logic        rst;
   logic [2:0]  addr;
   logic        we;
   logic [31:0] wd;
   logic [31:0] rd;
   logic        irq;
   logic [1:0]  irq_vec;

   int checks   = 0;
   int failures = 0;

`ifdef TIMER_PRESCALER_EN
   localparam logic [31:0] PS_CTRL_RD = 32'h0000_0301;
   localparam int          PS_ONE     = 6;
   localparam int          PS_PEND    = 10;
`else
   localparam logic [31:0] PS_CTRL_RD = 32'h0000_0001;
   localparam int          PS_ONE     = 3;
   localparam int          PS_PEND    = 4;
`endif

   localparam logic [2:0] C0_CTRL = 3'd0, C0_PRE = 3'd1, C0_CNT = 3'd2, C0_STAT = 3'd3;
   localparam logic [2:0] C1_CTRL = 3'd4, C1_PRE = 3'd5, C1_CNT = 3'd6, C1_STAT = 3'd7;

   multi_timer #(.CHANNELS(2), .WIDTH(32)) dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_addr   (addr),
      .i_we     (we),
      .i_wd     (wd),
      .o_rd     (rd),
      .o_irq    (irq),
      .o_irq_vec(irq_vec)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Write sampled at the next posedge; returns 1ns after that edge.
   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      addr = a; wd = d; we = 1'b1;
      @(posedge clk);
      #1;
      we = 1'b0;
   endtask

   task automatic chk_rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
      addr = a;
      #1;
      check(tag, rd, exp);
   endtask

   initial begin
      rst = 1'b1; we = 1'b0; addr = '0; wd = '0;
      tick(2);
      chk_rd("rst_ctrl0", C0_CTRL, 32'h0);
      chk_rd("rst_pre0", C0_PRE, 32'h0);
      chk_rd("rst_cnt1", C1_CNT, 32'h0);
      chk_rd("rst_stat1", C1_STAT, 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      check("rst_vec", 32'(irq_vec), 32'h0);
      rst = 1'b0;
      tick(1);

      // One-shot ch0, PRESET=3, EN+IM
      wr(C0_PRE, 32'd3);
      wr(C0_CTRL, 32'h9);
      tick(4);
      chk_rd("os_cnt_e4", C0_CNT, 32'd1);
      chk_rd("os_stat_e4", C0_STAT, 32'd0);
      tick(1);
      chk_rd("os_cnt_e5", C0_CNT, 32'd0);
      chk_rd("os_stat_e5", C0_STAT, 32'd1);
      check("os_vec_e5", 32'(irq_vec), 32'h1);
      check("os_irq_e5", 32'(irq), 32'h0);
      tick(1);
      check("os_irq_e6", 32'(irq), 32'h1);
      chk_rd("os_ctrl_e6", C0_CTRL, 32'h8);
      wr(C0_STAT, 32'h1);
      chk_rd("os_clr_stat", C0_STAT, 32'd0);
      check("os_clr_vec", 32'(irq_vec), 32'h0);
      check("os_clr_irq_lag", 32'(irq), 32'h1);
      tick(1);
      check("os_clr_irq", 32'(irq), 32'h0);

      // Auto-reload ch1, PRESET=4
      wr(C1_PRE, 32'd4);
      wr(C1_CTRL, 32'hB);
      tick(5);
      chk_rd("ar_cnt_e5", C1_CNT, 32'd1);
      chk_rd("ar_stat_e5", C1_STAT, 32'd0);
      tick(1);
      chk_rd("ar_stat_e6", C1_STAT, 32'd1);
      chk_rd("ar_cnt_e6", C1_CNT, 32'd0);
      check("ar_vec_e6", 32'(irq_vec), 32'h2);
      tick(1);
      chk_rd("ar_reload_e7", C1_CNT, 32'd4);
      check("ar_irq_e7", 32'(irq), 32'h1);
      tick(4);
      chk_rd("ar_cnt_e11", C1_CNT, 32'd0);
      tick(1);
      chk_rd("ar_cnt_e12", C1_CNT, 32'd4);
      chk_rd("ar_stat_kept", C1_STAT, 32'd1);
      tick(4);
      chk_rd("ar_cnt_e16", C1_CNT, 32'd0);
      wr(C1_STAT, 32'h0);
      chk_rd("ar_stat_w0", C1_STAT, 32'd1);
      wr(C1_STAT, 32'h1);
      chk_rd("ar_stat_w1", C1_STAT, 32'd0);
      check("ar_vec_clr", 32'(irq_vec), 32'h0);
      tick(1);
      check("ar_irq_clr", 32'(irq), 32'h0);
      wr(C1_CTRL, 32'h0);

      // Prescaler on ch0: PRESET=2, PRESCALE=3, IM=0
      wr(C0_PRE, 32'd2);
      wr(C0_CTRL, 32'h301);
      chk_rd("ps_ctrl", C0_CTRL, PS_CTRL_RD);
      tick(PS_ONE);
      chk_rd("ps_cnt_one", C0_CNT, 32'd1);
      tick(PS_PEND - PS_ONE - 1);
      chk_rd("ps_stat_before", C0_STAT, 32'd0);
      tick(1);
      chk_rd("ps_stat_at", C0_STAT, 32'd1);
      chk_rd("ps_cnt_at", C0_CNT, 32'd0);
      check("ps_vec_masked", 32'(irq_vec), 32'h0);

      // Simultaneous clear vs set on ch0, independent ch1 expiry
      wr(C1_PRE, 32'd3);
      wr(C0_PRE, 32'd3);
      wr(C0_CTRL, 32'h9);
      wr(C1_CTRL, 32'h9);
      tick(3);
      wr(C0_STAT, 32'h1);
      chk_rd("sim_stat0_a5", C0_STAT, 32'd0);
      chk_rd("sim_stat1_a5", C1_STAT, 32'd0);
      tick(1);
      chk_rd("sim_stat0_a6", C0_STAT, 32'd1);
      chk_rd("sim_stat1_a6", C1_STAT, 32'd1);
      check("sim_vec_a6", 32'(irq_vec), 32'h3);

      // Disable and restart ch0
      wr(C1_CTRL, 32'h0);
      wr(C0_PRE, 32'd5);
      wr(C0_CTRL, 32'h9);
      tick(3);
      chk_rd("dis_cnt_e3", C0_CNT, 32'd4);
      wr(C0_CTRL, 32'h8);
      chk_rd("dis_cnt_held", C0_CNT, 32'd4);
      tick(10);
      chk_rd("dis_cnt_idle", C0_CNT, 32'd4);
      chk_rd("dis_stat", C0_STAT, 32'd0);
      chk_rd("dis_ctrl", C0_CTRL, 32'h8);
      check("dis_vec", 32'(irq_vec), 32'h0);
      check("dis_irq", 32'(irq), 32'h0);
      wr(C0_CTRL, 32'h9);
      tick(2);
      chk_rd("rs_cnt_f2", C0_CNT, 32'd5);
      tick(4);
      chk_rd("rs_cnt_f6", C0_CNT, 32'd1);
      chk_rd("rs_stat_f6", C0_STAT, 32'd0);
      tick(1);
      chk_rd("rs_stat_f7", C0_STAT, 32'd1);

      // Reset in the middle of ch1 auto-reload counting with IRQ high
      wr(C1_PRE, 32'd4);
      wr(C1_CTRL, 32'hB);
      tick(7);
      check("mr_irq_pre", 32'(irq), 32'h1);
      chk_rd("mr_cnt_pre", C1_CNT, 32'd4);
      rst = 1'b1;
      tick(1);
      check("mr_irq", 32'(irq), 32'h0);
      check("mr_vec", 32'(irq_vec), 32'h0);
      chk_rd("mr_ctrl0", C0_CTRL, 32'h0);
      chk_rd("mr_stat0", C0_STAT, 32'h0);
      chk_rd("mr_ctrl1", C1_CTRL, 32'h0);
      chk_rd("mr_pre1", C1_PRE, 32'h0);
      chk_rd("mr_cnt1", C1_CNT, 32'h0);
      rst = 1'b0;
      tick(5);
      chk_rd("mr_cnt1_quiet", C1_CNT, 32'h0);
      check("mr_irq_quiet", 32'(irq), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
